// File: rtl/arm_source_scheduler.sv
// arm_source_scheduler: debounced source select plus rate-limited handover
// between the position memory and the accelerometer. Each axis output slews
// toward a shared target register at most STEP counts per tick.
// Optional feature macro: ARM_SCHED_WATCHDOG_EN (accel sample watchdog that
// forces a fallback to memory).

// One axis: target register plus slewing output register.
module arm_sched_lane #(
  parameter int DATA_W = 10,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              ld,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] out,
  output logic              near
);
  localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  logic [DATA_W-1:0] tgt, diff;
  logic              up;

  // Distance to target; near means the next tick lands exactly on it.
  always_comb begin
    up   = tgt > out;
    diff = up ? (tgt - out) : (out - tgt);
    near = diff <= STEP_V;
  end

  // Target capture and per-tick slew; the slew uses the pre-edge target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt <= MID;
      out <= MID;
    end else begin
      if (ld)   tgt <= sample;
      if (tick) out <= near ? tgt : (up ? out + STEP_V : out - STEP_V);
    end
  end
endmodule

module arm_source_scheduler #(
  parameter int DATA_W        = 10,
  parameter int TICK_DIV      = 500_000,
  parameter int STEP          = 4,
  parameter int HOLDOFF_TICKS = 8,
  parameter int WDOG_TICKS    = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              select_source,
  input  logic [DATA_W-1:0] x_mem,
  input  logic [DATA_W-1:0] y_mem,
  input  logic [DATA_W-1:0] z_mem,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] x_accel,
  input  logic [DATA_W-1:0] y_accel,
  input  logic [DATA_W-1:0] z_accel,
  input  logic              accel_valid,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] z_out,
  output logic              active_src,
  output logic              busy,
  output logic              fallback
);
  localparam int NUM_LANES = 3;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLDOFF_TICKS + 1);

  typedef enum logic [1:0] {S_MEM, S_RAMP_ACCEL, S_ACCEL, S_RAMP_MEM} state_t;

  state_t                              state;
  logic                                sel_q1, sel_s;
  logic [TW-1:0]                       tcnt;
  logic                                tick;
  logic [HW-1:0]                       hold_cnt;
  logic                                new_smp;
  logic                                mismatch, hold_hit, sw_req, done, own_ld;
  logic [NUM_LANES-1:0][DATA_W-1:0]    mem_v, acc_v, smp_v, out_v;
  logic [NUM_LANES-1:0]                near_v;

  // Two-flop synchronizer for the raw switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q1 <= 1'b0;
      sel_s  <= 1'b0;
    end else begin
      sel_q1 <= select_source;
      sel_s  <= sel_q1;
    end
  end

  // Free-running slew tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end
  assign tick = (tcnt == TW'(TICK_DIV - 1));

`ifdef ARM_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_TICKS + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_hit;
  assign wd_hit = tick && active_src && !accel_valid && (wd_cnt == WW'(WDOG_TICKS - 1));
`else
  // Watchdog depth has no effect in this build.
  logic unused_wdog;
  assign unused_wdog = ^WDOG_TICKS;
  assign fallback    = 1'b0;
`endif

  // Holdoff qualification and ramp-completion decode.
  always_comb begin
`ifdef ARM_SCHED_WATCHDOG_EN
    // In fallback the holdoff instead qualifies sel_s = 0 to re-arm accel.
    mismatch = fallback ? !sel_s : (sel_s != active_src);
`else
    mismatch = sel_s != active_src;
`endif
    hold_hit = tick && mismatch && (hold_cnt == HW'(HOLDOFF_TICKS - 1));
`ifdef ARM_SCHED_WATCHDOG_EN
    sw_req   = hold_hit && !fallback;
`else
    sw_req   = hold_hit;
`endif
    done     = tick && new_smp && (&near_v);
    own_ld   = active_src ? accel_valid : mem_valid;
  end

  // Handover FSM with registered active_src/busy/fallback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_MEM;
      active_src <= 1'b0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
      new_smp    <= 1'b0;
`ifdef ARM_SCHED_WATCHDOG_EN
      fallback   <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      if (!mismatch || hold_hit) hold_cnt <= '0;
      else if (tick)             hold_cnt <= hold_cnt + 1'b1;
      // A ramp may only finish once the new owner has delivered a sample.
      if (own_ld) new_smp <= 1'b1;
`ifdef ARM_SCHED_WATCHDOG_EN
      if (!active_src || accel_valid) wd_cnt <= '0;
      else if (tick)                  wd_cnt <= wd_cnt + 1'b1;
      if (fallback && hold_hit) fallback <= 1'b0;
`endif
      case (state)
        S_MEM: if (sw_req) begin
          state <= S_RAMP_ACCEL; active_src <= 1'b1; busy <= 1'b1; new_smp <= 1'b0;
        end
        S_ACCEL: if (sw_req) begin
          state <= S_RAMP_MEM; active_src <= 1'b0; busy <= 1'b1; new_smp <= 1'b0;
        end
        S_RAMP_ACCEL: if (sw_req) begin
          state <= S_RAMP_MEM; active_src <= 1'b0; new_smp <= 1'b0;
        end else if (done) begin
          state <= S_ACCEL; busy <= 1'b0;
        end
        S_RAMP_MEM: if (sw_req) begin
          state <= S_RAMP_ACCEL; active_src <= 1'b1; new_smp <= 1'b0;
        end else if (done) begin
          state <= S_MEM; busy <= 1'b0;
        end
        default: state <= S_MEM;
      endcase
`ifdef ARM_SCHED_WATCHDOG_EN
      if (wd_hit) begin
        state <= S_RAMP_MEM; active_src <= 1'b0; busy <= 1'b1;
        fallback <= 1'b1; new_smp <= 1'b0; wd_cnt <= '0;
      end
`endif
    end
  end

  assign mem_v = {z_mem, y_mem, x_mem};
  assign acc_v = {z_accel, y_accel, x_accel};
  assign smp_v = active_src ? acc_v : mem_v;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    arm_sched_lane #(.DATA_W(DATA_W), .STEP(STEP)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .ld     (own_ld),
      .sample (smp_v[i]),
      .out    (out_v[i]),
      .near   (near_v[i])
    );
  end

  assign x_out = out_v[0];
  assign y_out = out_v[1];
  assign z_out = out_v[2];
endmodule

// File: tb/tb_arm_source_scheduler.sv
// Scoreboard bench for arm_source_scheduler: each expected output snapshot is
// queued when stimulus is issued; the monitor pops one whenever the observed
// output vector changes and checks reset values while rst is high.
module tb_arm_source_scheduler;
  logic       clk, rst, select_source, mem_valid, accel_valid;
  logic [9:0] x_mem, y_mem, z_mem, x_accel, y_accel, z_accel;
  logic [9:0] x_out, y_out, z_out;
  logic       active_src, busy, fallback;
  logic       en_accel;

  typedef struct packed {
    logic [9:0] x, y, z;
    logic       act, bsy, fb;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  arm_source_scheduler #(
    .DATA_W(10), .TICK_DIV(4), .STEP(4), .HOLDOFF_TICKS(2), .WDOG_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .select_source(select_source),
    .x_mem(x_mem), .y_mem(y_mem), .z_mem(z_mem), .mem_valid(mem_valid),
    .x_accel(x_accel), .y_accel(y_accel), .z_accel(z_accel), .accel_valid(accel_valid),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .active_src(active_src), .busy(busy), .fallback(fallback)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic string fmt(input snap_t s);
    return $sformatf("x=%0d y=%0d z=%0d act=%0b busy=%0b fb=%0b", s.x, s.y, s.z, s.act, s.bsy, s.fb);
  endfunction

  function automatic void push(input int x, input int y, input int z,
                               input bit a, input bit b, input bit f);
    snap_t s;
    s.x = 10'(x); s.y = 10'(y); s.z = 10'(z);
    s.act = a; s.bsy = b; s.fb = f;
    exp_q.push_back(s);
  endfunction

  // Sample strobes every third cycle; accel strobe can be muted.
  initial begin
    mem_valid = 1'b0;
    accel_valid = 1'b0;
    forever begin
      repeat (2) @(negedge clk);
      mem_valid = 1'b1;
      accel_valid = en_accel;
      @(negedge clk);
      mem_valid = 1'b0;
      accel_valid = 1'b0;
    end
  end

  // Monitor: compare every output change against the next queued snapshot.
  initial begin
    snap_t cur, prev, e, rst_s;
    rst_s.x = 10'd512; rst_s.y = 10'd512; rst_s.z = 10'd512;
    rst_s.act = 1'b0; rst_s.bsy = 1'b0; rst_s.fb = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur.x = x_out; cur.y = y_out; cur.z = z_out;
      cur.act = active_src; cur.bsy = busy; cur.fb = fallback;
      if (rst) begin
        checks++;
        if (cur !== rst_s) begin
          errors++;
          $display("FAIL reset_state: got %s need %s", fmt(cur), fmt(rst_s));
        end
        prev = cur;
      end else if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %s need %s", fmt(cur), fmt(prev));
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL snapshot: got %s need %s", fmt(cur), fmt(e));
          end
        end
        prev = cur;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string nm, input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d snapshots still pending, need 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_x(input int v, input int lim);
    int n = 0;
    while (x_out != 10'(v) && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (x_out != 10'(v)) begin
      errors++;
      $display("FAIL wait_x: got x=%0d need %0d", x_out, v);
    end
  endtask

  // Asynchronous assert away from any edge; release with defaults applied.
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    select_source = 1'b0; en_accel = 1'b1;
    x_mem = 10'd512; y_mem = 10'd512; z_mem = 10'd512;
    x_accel = 10'd512; y_accel = 10'd512; z_accel = 10'd512;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; select_source = 1'b0; en_accel = 1'b1;
    x_mem = 10'd512; y_mem = 10'd512; z_mem = 10'd512;
    x_accel = 10'd512; y_accel = 10'd512; z_accel = 10'd512;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Memory sample slews per axis, z unchanged.
    x_mem = 10'd520; y_mem = 10'd500; z_mem = 10'd512;
    push(516, 508, 512, 0, 0, 0);
    push(520, 504, 512, 0, 0, 0);
    push(520, 500, 512, 0, 0, 0);
    drain("mem_slew", 100);
    idle(16);

    // One-tick switch pulse is rejected; a held switch hands over, then ramp.
    do_reset();
    x_accel = 10'd600;
    select_source = 1'b1;
    repeat (4) @(negedge clk);
    select_source = 1'b0;
    idle(20);
    push(512, 512, 512, 1, 1, 0);
    for (int i = 1; i <= 21; i++) push(512 + 4 * i, 512, 512, 1, 1, 0);
    push(600, 512, 512, 1, 0, 0);
    select_source = 1'b1;
    drain("accel_ramp", 300);
    idle(16);

    // Reverse mid-ramp: handover lands on the tick that reaches 560.
    do_reset();
    x_accel = 10'd600;
    push(512, 512, 512, 1, 1, 0);
    for (int i = 1; i <= 10; i++) push(512 + 4 * i, 512, 512, 1, 1, 0);
    select_source = 1'b1;
    wait_x(552, 300);
    select_source = 1'b0;
    push(556, 512, 512, 1, 1, 0);
    push(560, 512, 512, 0, 1, 0);
    for (int i = 1; i <= 11; i++) push(560 - 4 * i, 512, 512, 0, 1, 0);
    push(512, 512, 512, 0, 0, 0);
    drain("reverse_ramp", 300);
    idle(16);

    // Settle at 530, start a ramp, then reset while busy.
    do_reset();
    x_mem = 10'd530; x_accel = 10'd600;
    for (int i = 1; i <= 4; i++) push(512 + 4 * i, 512, 512, 0, 0, 0);
    push(530, 512, 512, 0, 0, 0);
    drain("mem_to_530", 100);
    push(530, 512, 512, 1, 1, 0);
    select_source = 1'b1;
    drain("switch_at_530", 100);
    do_reset();
    idle(8);

`ifdef ARM_SCHED_WATCHDOG_EN
    // Accel goes silent: fallback to memory, blocked until switch returns to 0.
    push(512, 512, 512, 1, 1, 0);
    push(512, 512, 512, 1, 0, 0);
    select_source = 1'b1;
    drain("wd_accel_settle", 100);
    en_accel = 1'b0;
    push(512, 512, 512, 0, 1, 1);
    push(512, 512, 512, 0, 0, 1);
    drain("wd_fallback", 200);
    idle(40);
    push(512, 512, 512, 0, 0, 0);
    select_source = 1'b0;
    drain("wd_release", 100);
    push(512, 512, 512, 1, 1, 0);
    push(512, 512, 512, 1, 0, 0);
    en_accel = 1'b1;
    select_source = 1'b1;
    drain("wd_reselect", 100);
    idle(16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
